interrupt_request_ctrl: RTL and testbench
=========================================

// Module: interrupt_request_ctrl
// PURPOSE
//  Initiator side of the interrupt handshake with the CP0 register block.
//  Synchronises external interrupt lines and latches their rising edges as pending.
//  Prioritises the pending lines against the CP0 mask, global enable and current nesting level.
//  Presents one request/code pair to CP0, tracks nested in-service levels, and releases a level on eret.
// PARAMETERS
//  N_IRQ   3  number of interrupt lines; line i carries code i+1, and a higher code has higher priority
//  CODE_W  2  width of out_code; must satisfy 2**CODE_W > N_IRQ
// PORTS
//  in_clk      in   1       system clock, rising edge
//  in_RST      in   1       reset, asynchronous, active-low
//  in_irq      in   N_IRQ   raw external interrupt lines, asynchronous to in_clk
//  in_INM      in   N_IRQ   per-line mask from CP0; 1 = masked
//  in_IE       in   1       global interrupt enable from CP0
//  in_ack      in   1       one-cycle pulse: CP0 has taken the current request
//  in_eret     in   1       one-cycle pulse: return from the current handler
//  out_req     out  1       interrupt request to CP0 (the NIE/BK side)
//  out_code    out  CODE_W  code of the requested line; 0 when out_req=0
//  out_pending out  N_IRQ   latched pending bits
//  out_level   out  CODE_W  code currently in service; 0 = none
// BEHAVIOUR
//  Reset (in_RST=0, async): all outputs, sync flops, pending bits, level stack and FSM go to 0/IDLE.
//  Input conditioning:
//   - Two-flop synchroniser per line, then a third flop for edge detect.
//   - A rising edge sampled at clock edge k sets its pending bit at edge k+3.
//  Eligibility:
//   - A line is eligible when pending & ~in_INM & in_IE and its code > out_level.
//   - The winner is the highest eligible code.
//  FSM IDLE:
//   - Any eligible line -> REQ on the next edge.
//   - On that edge, out_req<=1 and out_code<=winner.
//  FSM REQ:
//   - out_code is held stable while out_req=1.
//   - A higher-priority arrival does not preempt an unacked request.
//   - in_ack -> out_req<=0, out_code<=0, clear pending[code-1], push out_level, out_level<=code. Go to HOLD.
//   - No ack, and the requested line becomes ineligible (mask, IE drop, or raised level) -> withdraw:
//     out_req<=0, out_code<=0, go to IDLE. The pending bit is kept.
//  FSM HOLD:
//   - One-cycle holdoff so CP0 can update IE/INM, then go to IDLE.
//  Level stack:
//   - Depth N_IRQ. It cannot overflow, because every push strictly raises the level.
//   - in_eret pops: out_level <= top, or 0 if the stack is empty.
//   - in_eret with an empty stack and out_level=0 is ignored.
//  Simultaneous events:
//   - Ack and eret in the same cycle: pop first, then push. Stack depth is unchanged; out_level = acked code.
//   - New edge on a line in the same cycle its pending bit is cleared by ack: the bit stays 1 (new event).
//   - Two edges on one line before service collapse into one pending event.
//   - in_ack while out_req=0 is ignored.
//  Width: codes compare unsigned at CODE_W bits.
// TESTING
//  1. in_IE=1, in_INM=0, line0 edge at edge 10 -> pending[0]=1 at 13, out_req=1 and out_code=1 at 14.
//     Ack at 16 -> out_level=1, pending=0.
//  2. Lines 0 and 2 rise together -> out_code=3.
//     Ack -> level=3, then out_req=1 and out_code=1 after HOLD only once eret returns level to 0.
//  3. Nesting: level=1 while serving, line 1 rises -> out_code=2.
//     Ack -> level=2; eret -> level=1; eret -> level=0.
//  4. in_INM[1]=1 with pending line 1 -> no out_req.
//     Mask cleared -> out_req=1, code=2.
//     IE dropped during REQ -> out_req=0 next edge, pending[1] still 1.
//  5. Ack and eret same cycle at level=1 with code=3 requested -> level=3, depth 1.
//     Later eret -> level 0.
//  6. in_RST pulled low mid-REQ, asynchronously -> out_req, out_code, out_level, out_pending = 0 immediately.
//     After release, no request without a new edge.

Source files
------------

// File: rtl/interrupt_request_ctrl.sv
// Interrupt request initiator towards CP0: synchronises lines, latches
// edges, arbitrates by code and tracks nested in-service levels.
module interrupt_request_ctrl #(
    parameter int N_IRQ  = 3,
    parameter int CODE_W = 2
) (
    input  logic              in_clk,
    input  logic              in_RST,
    input  logic [N_IRQ-1:0]  in_irq,
    input  logic [N_IRQ-1:0]  in_INM,
    input  logic              in_IE,
    input  logic              in_ack,
    input  logic              in_eret,
    output logic              out_req,
    output logic [CODE_W-1:0] out_code,
    output logic [N_IRQ-1:0]  out_pending,
    output logic [CODE_W-1:0] out_level
);

    localparam int SP_W = $clog2(N_IRQ + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_e;

    state_e             state_q;
    logic [N_IRQ-1:0]   s1_q;
    logic [N_IRQ-1:0]   s2_q;
    logic [N_IRQ-1:0]   s3_q;
    logic [N_IRQ-1:0]   edge_q;
    logic [CODE_W-1:0]  stack_q [N_IRQ];
    logic [SP_W-1:0]    sp_q;

    logic [N_IRQ-1:0]   elig;
    logic [N_IRQ-1:0]   sel;
    logic [N_IRQ-1:0]   clr;
    logic [CODE_W-1:0]  win;
    logic               req_ok;
    logic               take;
    logic [CODE_W-1:0]  lvl_d;
    logic [SP_W-1:0]    sp_d;

    always_comb begin
        elig = '0;
        sel  = '0;
        win  = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            elig[i] = out_pending[i] & ~in_INM[i] & in_IE
                    & (CODE_W'(i + 1) > out_level);
            sel[i]  = (out_code == CODE_W'(i + 1));
            if (elig[i]) begin
                win = CODE_W'(i + 1);
            end
        end
        req_ok = |(elig & sel);
        take   = (state_q == REQ) & in_ack;
        clr    = sel & {N_IRQ{take}};
    end

    // Pop happens before any push so ack+eret leaves depth unchanged.
    always_comb begin
        lvl_d = out_level;
        sp_d  = sp_q;
        if (in_eret) begin
            if (sp_q != '0) begin
                sp_d  = sp_q - SP_W'(1);
                lvl_d = stack_q[sp_d];
            end else begin
                lvl_d = '0;
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_RST) begin
        if (!in_RST) begin
            state_q     <= IDLE;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            edge_q      <= '0;
            sp_q        <= '0;
            out_req     <= 1'b0;
            out_code    <= '0;
            out_pending <= '0;
            out_level   <= '0;
            for (int i = 0; i < N_IRQ; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            s1_q        <= in_irq;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            edge_q      <= s2_q & ~s3_q;
            out_pending <= (out_pending & ~clr) | edge_q;
            out_level   <= lvl_d;
            sp_q        <= sp_d;
            unique case (state_q)
                IDLE: begin
                    if (|elig) begin
                        state_q  <= REQ;
                        out_req  <= 1'b1;
                        out_code <= win;
                    end
                end
                REQ: begin
                    if (in_ack) begin
                        stack_q[sp_d] <= lvl_d;
                        sp_q          <= sp_d + SP_W'(1);
                        out_level     <= out_code;
                        out_req       <= 1'b0;
                        out_code      <= '0;
                        state_q       <= HOLD;
                    end else if (!req_ok) begin
                        out_req  <= 1'b0;
                        out_code <= '0;
                        state_q  <= IDLE;
                    end
                end
                HOLD: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_request_ctrl.sv
// Bench for interrupt_request_ctrl: directed vectors, literal checks and
// a per-cycle comparison against an event-level model.
module tb_interrupt_request_ctrl;

    logic       clk;
    logic       rst_n;
    logic [2:0] irq;
    logic [2:0] inm;
    logic       ie;
    logic       ack;
    logic       eret;
    logic       req;
    logic [1:0] code;
    logic [2:0] pend;
    logic [1:0] lvl;

    int checks;
    int errors;

    interrupt_request_ctrl #(.N_IRQ(3), .CODE_W(2)) dut (
        .in_clk     (clk),
        .in_RST     (rst_n),
        .in_irq     (irq),
        .in_INM     (inm),
        .in_IE      (ie),
        .in_ack     (ack),
        .in_eret    (eret),
        .out_req    (req),
        .out_code   (code),
        .out_pending(pend),
        .out_level  (lvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: rise events travel through a 3-edge delay line.
    logic [2:0] m_pend;
    logic [2:0] m_prev;
    logic [2:0] m_dly [3];
    int         m_req;
    int         m_lvl;
    bit         m_hold;
    int         m_stk [$];

    function automatic bit m_elig(int c);
        return m_pend[c-1] && !inm[c-1] && ie && (c > m_lvl);
    endfunction

    task automatic m_reset();
        m_pend = '0;
        m_prev = '0;
        for (int i = 0; i < 3; i++) m_dly[i] = '0;
        m_req  = 0;
        m_lvl  = 0;
        m_hold = 0;
        m_stk.delete();
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
            end else begin
                int         best;
                int         nl;
                logic [2:0] setv;
                logic [2:0] clrv;
                best = 0;
                for (int c = 1; c <= 3; c++) if (m_elig(c)) best = c;
                setv     = m_dly[2];
                m_dly[2] = m_dly[1];
                m_dly[1] = m_dly[0];
                m_dly[0] = irq & ~m_prev;
                m_prev   = irq;
                clrv = '0;
                nl   = m_lvl;
                if (eret) nl = (m_stk.size() > 0) ? m_stk.pop_back() : 0;
                if (m_req != 0 && ack) begin
                    clrv[m_req-1] = 1'b1;
                    m_stk.push_back(nl);
                    nl     = m_req;
                    m_req  = 0;
                    m_hold = 1;
                end else begin
                    if (m_req != 0) begin
                        if (!m_elig(m_req)) m_req = 0;
                    end else if (!m_hold && best > 0) begin
                        m_req = best;
                    end
                    m_hold = 0;
                end
                m_pend = (m_pend & ~clrv) | setv;
                m_lvl  = nl;
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("model req", 32'(req), 32'(m_req != 0));
                chk("model code", 32'(code), 32'(m_req));
                chk("model pending", 32'(pend), 32'(m_pend));
                chk("model level", 32'(lvl), 32'(m_lvl));
            end
        end
    end

    task automatic step(int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        step();
        eret = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        irq    = '0;
        inm    = '0;
        ie     = 1'b1;
        ack    = 1'b0;
        eret   = 1'b0;
        step(2);
        chk("reset req", 32'(req), 0);
        chk("reset code", 32'(code), 0);
        chk("reset pending", 32'(pend), 0);
        chk("reset level", 32'(lvl), 0);
        rst_n = 1'b1;
        step(2);

        // Single line: pending at k+3, request at k+4, ack raises level.
        irq = 3'b001;
        step(3);
        chk("t1 pend before", 32'(pend), 0);
        step();
        chk("t1 pend set", 32'(pend), 1);
        chk("t1 req early", 32'(req), 0);
        step();
        chk("t1 req", 32'(req), 1);
        chk("t1 code", 32'(code), 1);
        irq = '0;
        do_ack();
        chk("t1 level", 32'(lvl), 1);
        chk("t1 pend clr", 32'(pend), 0);
        chk("t1 req drop", 32'(req), 0);
        step(3);

        // Nesting on top of level 1.
        irq = 3'b010;
        step(5);
        chk("t3 code", 32'(code), 2);
        irq = '0;
        do_ack();
        chk("t3 level2", 32'(lvl), 2);
        step(2);
        do_eret();
        chk("t3 eret1", 32'(lvl), 1);
        do_eret();
        chk("t3 eret0", 32'(lvl), 0);
        do_eret();
        chk("t3 eret idle", 32'(lvl), 0);
        step(2);

        // Two lines together: highest wins, lower waits for level 0.
        irq = 3'b101;
        step(5);
        chk("t2 code", 32'(code), 3);
        irq = '0;
        do_ack();
        chk("t2 level", 32'(lvl), 3);
        chk("t2 pend", 32'(pend), 1);
        step(4);
        chk("t2 blocked", 32'(req), 0);
        do_eret();
        chk("t2 lvl0", 32'(lvl), 0);
        step();
        chk("t2 req low", 32'(req), 1);
        chk("t2 code low", 32'(code), 1);
        do_ack();
        do_eret();
        step(2);

        // Mask, unmask, then IE drop withdraws but keeps pending.
        inm = 3'b010;
        irq = 3'b010;
        step(4);
        irq = '0;
        step(3);
        chk("t4 masked", 32'(req), 0);
        chk("t4 pend", 32'(pend), 2);
        inm = '0;
        step();
        chk("t4 unmask code", 32'(code), 2);
        ie = 1'b0;
        step();
        chk("t4 withdraw", 32'(req), 0);
        chk("t4 keep pend", 32'(pend), 2);
        ie = 1'b1;
        step();
        chk("t4 rereq", 32'(req), 1);
        do_ack();
        do_eret();
        step(2);

        // Ack and eret together at level 1.
        irq = 3'b001;
        step(5);
        irq = '0;
        do_ack();
        irq = 3'b100;
        step(5);
        chk("t5 code", 32'(code), 3);
        irq = '0;
        ack  = 1'b1;
        eret = 1'b1;
        step();
        ack  = 1'b0;
        eret = 1'b0;
        chk("t5 level3", 32'(lvl), 3);
        step(2);
        do_eret();
        chk("t5 lvl0", 32'(lvl), 0);
        do_eret();
        chk("t5 lvl0 again", 32'(lvl), 0);
        step(2);

        // New edge lands in the same cycle the pending bit is cleared.
        irq = 3'b001;
        step(5);
        irq = '0;
        step();
        irq = 3'b001;
        step();
        irq = '0;
        step(2);
        do_ack();
        chk("t7 pend kept", 32'(pend), 1);
        chk("t7 level", 32'(lvl), 1);
        step(3);
        chk("t7 no req", 32'(req), 0);
        do_eret();
        step();
        chk("t7 req again", 32'(code), 1);
        do_ack();
        do_eret();
        step(2);

        // Asynchronous reset mid-request.
        irq = 3'b010;
        step(5);
        chk("t6 req", 32'(req), 1);
        irq = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst req", 32'(req), 0);
        chk("t6 rst code", 32'(code), 0);
        chk("t6 rst pend", 32'(pend), 0);
        chk("t6 rst level", 32'(lvl), 0);
        step();
        rst_n = 1'b1;
        step(6);
        chk("t6 quiet req", 32'(req), 0);
        chk("t6 quiet pend", 32'(pend), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
